// File: rtl/reg_write_port.sv
// Register file write side: in-order write-back queue feeding sixteen DW-bit registers through a
// one-hot load decode, with a pending bitmap of queued destinations for hazard checks.
module reg_write_port #(
  parameter int unsigned DW      = 16,
  parameter int unsigned NREG    = 16,
  parameter int unsigned DEPTH   = 2,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [3:0]      wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic            wb_hold,
  input  logic            flush,
  output logic            wb_done,
  output logic [3:0]      wb_addr,
  output logic [NREG-1:0] pend,
  output logic [DW-1:0]   out0,
  output logic [DW-1:0]   out1,
  output logic [DW-1:0]   out2,
  output logic [DW-1:0]   out3,
  output logic [DW-1:0]   out4,
  output logic [DW-1:0]   out5,
  output logic [DW-1:0]   out6,
  output logic [DW-1:0]   out7,
  output logic [DW-1:0]   out8,
  output logic [DW-1:0]   out9,
  output logic [DW-1:0]   out10,
  output logic [DW-1:0]   out11,
  output logic [DW-1:0]   out12,
  output logic [DW-1:0]   out13,
  output logic [DW-1:0]   out14,
  output logic [DW-1:0]   out15
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [3:0]      q_addr_q [DEPTH];
  logic [3:0]      q_addr_d [DEPTH];
  logic [DW-1:0]   q_data_q [DEPTH];
  logic [DW-1:0]   q_data_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic            wb_done_q, wb_done_d;
  logic [3:0]      wb_addr_q, wb_addr_d;

  logic            full, empty, accept, retire;
  logic [3:0]      head_addr;
  logic [DW-1:0]   head_data;
  logic [NREG-1:0] wr_en;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr_ready  = ~full & ~flush;
  assign accept    = wr_valid & wr_ready;
  assign retire    = ~empty & ~wb_hold & ~flush;
  assign head_addr = q_addr_q[rd_ptr_q];
  assign head_data = q_data_q[rd_ptr_q];

  // Queue bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    q_addr_d = q_addr_q;
    q_data_d = q_data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        q_addr_d[wr_ptr_q] = wr_addr;
        q_data_d[wr_ptr_q] = wr_data;
        wr_ptr_d           = wr_ptr_q + PW'(1);
      end
      if (retire) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({accept, retire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    wr_en = '0;
    if (retire) begin
      wr_en[head_addr] = 1'b1;
    end
    // Retire to r0 still pops and reports, but never loads the register.
    if (ZERO_R0) begin
      wr_en[0] = 1'b0;
    end
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = wr_en[i] ? head_data : regs_q[i];
    end
    wb_done_d = retire;
    wb_addr_d = retire ? head_addr : wb_addr_q;
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        pend[q_addr_q[rd_ptr_q + PW'(i)]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_addr_q[i] <= '0;
        q_data_q[i] <= '0;
      end
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wb_done_q <= 1'b0;
      wb_addr_q <= '0;
    end else begin
      q_addr_q  <= q_addr_d;
      q_data_q  <= q_data_d;
      regs_q    <= regs_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wb_done_q <= wb_done_d;
      wb_addr_q <= wb_addr_d;
    end
  end

  assign wb_done = wb_done_q;
  assign wb_addr = wb_addr_q;

  assign out0  = regs_q[0];
  assign out1  = regs_q[1];
  assign out2  = regs_q[2];
  assign out3  = regs_q[3];
  assign out4  = regs_q[4];
  assign out5  = regs_q[5];
  assign out6  = regs_q[6];
  assign out7  = regs_q[7];
  assign out8  = regs_q[8];
  assign out9  = regs_q[9];
  assign out10 = regs_q[10];
  assign out11 = regs_q[11];
  assign out12 = regs_q[12];
  assign out13 = regs_q[13];
  assign out14 = regs_q[14];
  assign out15 = regs_q[15];

endmodule

// File: tb/tb_reg_write_port.sv
// Bench for reg_write_port: two instances (ZERO_R0 off/on) share stimulus; a queue-level model
// predicts retirements into a scoreboard that a separate monitor drains on every WB_DONE.
module tb_reg_write_port;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [3:0]    addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic [3:0]    addr;
    logic [DW-1:0] va;
    logic [DW-1:0] vb;
  } sb_t;

  logic                  clk;
  logic                  rst_n;
  logic                  wr_valid;
  logic [3:0]            wr_addr;
  logic [DW-1:0]         wr_data;
  logic                  wb_hold;
  logic                  flush;
  logic                  wr_ready_a, wr_ready_b;
  logic                  wb_done_a, wb_done_b;
  logic [3:0]            wb_addr_a, wb_addr_b;
  logic [15:0]           pend_a, pend_b;
  logic [15:0][DW-1:0]   oa;
  logic [15:0][DW-1:0]   ob;

  int tests = 0;
  int fails = 0;

  ent_t          mq[$];
  sb_t           sb[$];
  logic [DW-1:0] ma [16];
  logic [DW-1:0] mb [16];

  reg_write_port #(.DW(DW), .NREG(16), .DEPTH(DEPTH), .ZERO_R0(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_addr(wr_addr),
    .wr_data(wr_data), .wb_hold(wb_hold), .flush(flush), .wb_done(wb_done_a),
    .wb_addr(wb_addr_a), .pend(pend_a),
    .out0(oa[0]), .out1(oa[1]), .out2(oa[2]), .out3(oa[3]), .out4(oa[4]), .out5(oa[5]),
    .out6(oa[6]), .out7(oa[7]), .out8(oa[8]), .out9(oa[9]), .out10(oa[10]), .out11(oa[11]),
    .out12(oa[12]), .out13(oa[13]), .out14(oa[14]), .out15(oa[15])
  );

  reg_write_port #(.DW(DW), .NREG(16), .DEPTH(DEPTH), .ZERO_R0(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_addr(wr_addr),
    .wr_data(wr_data), .wb_hold(wb_hold), .flush(flush), .wb_done(wb_done_b),
    .wb_addr(wb_addr_b), .pend(pend_b),
    .out0(ob[0]), .out1(ob[1]), .out2(ob[2]), .out3(ob[3]), .out4(ob[4]), .out5(ob[5]),
    .out6(ob[6]), .out7(ob[7]), .out8(ob[8]), .out9(ob[9]), .out10(ob[10]), .out11(ob[11]),
    .out12(ob[12]), .out13(ob[13]), .out14(ob[14]), .out15(ob[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pend();
    logic [15:0] p = '0;
    foreach (mq[i]) p[mq[i].addr] = 1'b1;
    return p;
  endfunction

  task automatic model_clear();
    mq.delete();
    sb.delete();
    for (int i = 0; i < 16; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
  endtask

  task automatic check_reset();
    chk("rst_ready_a", 32'(wr_ready_a), 32'd1);
    chk("rst_ready_b", 32'(wr_ready_b), 32'd1);
    chk("rst_pend_a", 32'(pend_a), 32'd0);
    chk("rst_pend_b", 32'(pend_b), 32'd0);
    chk("rst_done_a", 32'(wb_done_a), 32'd0);
    chk("rst_done_b", 32'(wb_done_b), 32'd0);
    chk("rst_wbaddr_a", 32'(wb_addr_a), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rst_out_a%0d", i), 32'(oa[i]), 32'd0);
      chk($sformatf("rst_out_b%0d", i), 32'(ob[i]), 32'd0);
    end
  endtask

  // One clock of stimulus, starting and ending at a falling edge.
  task automatic cycle(input logic v, input logic [3:0] a, input logic [DW-1:0] d,
                       input logic h, input logic f);
    logic rdy_m, ret_m, acc_m;
    ent_t e;
    sb_t  s;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    wb_hold  = h;
    flush    = f;
    #1;
    rdy_m = (mq.size() < DEPTH) && !f;
    ret_m = (mq.size() > 0) && !h && !f;
    acc_m = v && rdy_m;
    chk("wr_ready_a", 32'(wr_ready_a), 32'(rdy_m));
    chk("wr_ready_b", 32'(wr_ready_b), 32'(rdy_m));
    chk("pend_a", 32'(pend_a), 32'(model_pend()));
    chk("pend_b", 32'(pend_b), 32'(model_pend()));
    @(posedge clk);
    if (f) begin
      mq.delete();
    end else begin
      if (ret_m) begin
        e = mq.pop_front();
        ma[e.addr] = e.data;
        if (e.addr != 4'd0) mb[e.addr] = e.data;
        s.addr = e.addr;
        s.va   = ma[e.addr];
        s.vb   = mb[e.addr];
        sb.push_back(s);
      end
      if (acc_m) begin
        e.addr = a;
        e.data = d;
        mq.push_back(e);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("out_a%0d", i), 32'(oa[i]), 32'(ma[i]));
      chk($sformatf("out_b%0d", i), 32'(ob[i]), 32'(mb[i]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, '0, 1'b0, 1'b0);
  endtask

  task automatic mid_reset();
    wr_valid = 1'b0;
    wb_hold  = 1'b1;
    flush    = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every WB_DONE must match the oldest predicted retirement, and vice versa.
  always @(negedge clk) begin
    sb_t s;
    if (wb_done_a || wb_done_b) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wb_unexpected: done a=%b b=%b addr=%h, expected no retirement",
                 wb_done_a, wb_done_b, wb_addr_a);
      end else begin
        s = sb.pop_front();
        chk("wb_done_a", 32'(wb_done_a), 32'd1);
        chk("wb_done_b", 32'(wb_done_b), 32'd1);
        chk("wb_addr_a", 32'(wb_addr_a), 32'(s.addr));
        chk("wb_addr_b", 32'(wb_addr_b), 32'(s.addr));
        chk("wb_val_a", 32'(oa[s.addr]), 32'(s.va));
        chk("wb_val_b", 32'(ob[s.addr]), 32'(s.vb));
      end
    end else if (sb.size() != 0) begin
      s = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL wb_missing: got no WB_DONE, expected retirement to r%0d", s.addr);
    end
  end

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wb_hold  = 1'b0;
    flush    = 1'b0;
    model_clear();
    #1;
    check_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single write, then hold/backpressure.
    cycle(1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b0);
    idle(2);
    cycle(1'b1, 4'd3, 16'h1111, 1'b1, 1'b0);
    cycle(1'b1, 4'd7, 16'h2222, 1'b1, 1'b0);
    cycle(1'b1, 4'd9, 16'h3333, 1'b1, 1'b0);
    idle(3);
    // Same-address ordering.
    cycle(1'b1, 4'd9, 16'hAAAA, 1'b0, 1'b0);
    cycle(1'b1, 4'd9, 16'h5555, 1'b0, 1'b0);
    idle(3);
    // Flush discards held entries.
    cycle(1'b1, 4'd1, 16'h1234, 1'b1, 1'b0);
    cycle(1'b1, 4'd2, 16'h5678, 1'b1, 1'b0);
    cycle(1'b1, 4'd6, 16'h9999, 1'b1, 1'b1);
    idle(2);
    // r0 and r15 writes.
    cycle(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0);
    cycle(1'b1, 4'd15, 16'hFFFF, 1'b0, 1'b0);
    idle(2);
    // Asynchronous reset with two entries queued.
    cycle(1'b1, 4'd4, 16'h4444, 1'b1, 1'b0);
    cycle(1'b1, 4'd8, 16'h8888, 1'b1, 1'b0);
    mid_reset();
    idle(3);

    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 99) < 70, 4'($urandom_range(0, 15)), DW'($urandom),
            $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5);
    end
    idle(DEPTH + 2);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("model_drained", 32'(mq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_write_port.md
# reg_write_port

General-purpose register file write side for the 16-bit RISC datapath. Accepts write-back requests (address + data) over a valid/ready handshake, buffers them in a small in-order queue, decodes the 4-bit address to a one-hot load enable and updates one of sixteen 16-bit registers per cycle. The registers drive the sixteen parallel outputs consumed by the read-port multiplexers. A pending bitmap exposes in-flight writes for hazard checks.

## Interface
- DW, 16, register data width
- NREG, 16, number of registers (address width fixed at 4)
- DEPTH, 2, write queue depth (power of two, ≥2)
- ZERO_R0, 0, when 1 register 0 is hardwired to zero and writes to it are discarded at retire
- CLK  input  1  single clock, all state on rising edge
- RST_N  input  1  reset, asynchronous and active-low
- WR_VALID  input  1  write request present
- WR_READY  output  1  queue can accept a request this cycle
- WR_ADDR  input  4  destination register
- WR_DATA  input  DW  write data
- WB_HOLD  input  1  stall retirement (queue holds, accepts still allowed)
- FLUSH  input  1  synchronous queue discard
- WB_DONE  output  1  one-cycle pulse: a register was updated on this edge
- WB_ADDR  output  4  address of the retired write, valid with WB_DONE
- PEND  output  NREG  bit i set while a write to register i is queued
- OUT0..OUT15  output  DW each  current register contents

## Operation
- Accept: WR_VALID & WR_READY at a rising edge pushes {WR_ADDR, WR_DATA} at the queue tail.
- WR_READY = ~full & ~FLUSH; purely a function of registered count and FLUSH, never of WR_VALID or WB_HOLD.
- Retire: when queue non-empty, WB_HOLD=0, FLUSH=0: head popped, register[head.addr] ← head.data via one-hot decode; exactly one register changes; WB_DONE=1, WB_ADDR=head.addr on the following cycle.
- ZERO_R0=1: retire of address 0 pops the entry, asserts WB_DONE, leaves OUT0 = 0.
- Strict FIFO order; back-to-back writes to the same address retire in order, last one wins.
- Simultaneous accept and retire: both occur; count unchanged. Full queue with retire in same cycle: no accept (WR_READY already low), no overflow.
- FLUSH=1: queue emptied at the edge, no retire, no accept; registers untouched; WB_DONE=0 next cycle.
- PEND[i] = OR over valid queue entries of (addr == i); combinational from queue state, clears on the edge the last pending entry to i retires or on FLUSH.
- Count arithmetic: pointers wrap modulo DEPTH; count in 0..DEPTH, full = (count == DEPTH), empty = (count == 0).

## Timing
- Reset (RST_N low, asynchronous): all registers 0, queue empty, pointers 0, WB_DONE 0, WB_ADDR 0, PEND 0, WR_READY 1 (FLUSH low). Reset mid-operation discards queued writes; no partial register update.
- Latency, empty queue, WB_HOLD low: request accepted at edge N, retired at edge N+1; OUTx and WB_DONE reflect it after N+1. No combinational bypass from WR_DATA to OUTx.
- Throughput: one write per cycle sustained with WB_HOLD low.
- WB_HOLD high for k cycles delays retirement by k cycles; up to DEPTH requests accepted meanwhile, then WR_READY low.
- WR_DATA/WR_ADDR sampled only on accept edges; values held while WR_READY low are ignored.

## Test plan
- Reset then single write: WR_ADDR=5, WR_DATA=0xBEEF accepted edge 1 -> OUT5=0xBEEF after edge 2, WB_DONE pulse with WB_ADDR=5, PEND[5] high for exactly one cycle, all other OUTx=0.
- Hold/backpressure: WB_HOLD=1, push 0x1111→R3, 0x2222→R7 -> WR_READY low after second accept, PEND=0x0088; release hold -> R3 updated then R7 on consecutive edges, WR_READY high again.
- Same-address ordering: back-to-back 0xAAAA then 0x5555 to R9 -> OUT9 shows 0xAAAA for one cycle then 0x5555; two WB_DONE pulses.
- Flush: queue 2 writes under hold, assert FLUSH one cycle -> PEND=0, no WB_DONE, OUTx unchanged, WR_READY low during FLUSH cycle only.
- ZERO_R0=1: write 0xFFFF to R0 -> WB_DONE with WB_ADDR=0, OUT0 stays 0x0000; write 0xFFFF to R15 -> OUT15=0xFFFF.
- Async reset mid-stream: RST_N low between clock edges with 2 entries queued -> all outputs to reset values immediately, no retire after RST_N rises until new accept.
